// File: rtl/mem_access_if.sv
// Upstream handshake, writeback payload and data-memory bus of the MIPS
// memory-access stage, bundled so the stage and its neighbours share one view.
interface mem_access_if #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32
);
    logic                m_i_valid;
    logic                m_o_ready;
    logic [DWIDTH-1:0]   m_i_alu_value;
    logic [DWIDTH-1:0]   m_i_data_rt;
    logic [PC_WIDTH-1:0] m_i_alu_pc;
    logic                m_i_mem_read;
    logic                m_i_mem_write;
    logic [1:0]          m_i_size;
    logic                m_i_unsigned;
    logic [4:0]          m_i_rd_addr;
    logic                m_i_reg_write;

    logic                m_o_req;
    logic                m_o_we;
    logic [DWIDTH-1:0]   m_o_addr;
    logic [DWIDTH-1:0]   m_o_wdata;
    logic [3:0]          m_o_wstrb;
    logic                m_i_ack;
    logic [DWIDTH-1:0]   m_i_rdata;

    logic                m_o_valid;
    logic [DWIDTH-1:0]   m_o_wb_data;
    logic [4:0]          m_o_rd_addr;
    logic                m_o_reg_write;
    logic [PC_WIDTH-1:0] m_o_pc;
    logic                m_o_misalign;
    logic                m_o_timeout;

    // The memory stage itself
    modport slave (
        input  m_i_valid, m_i_alu_value, m_i_data_rt, m_i_alu_pc,
               m_i_mem_read, m_i_mem_write, m_i_size, m_i_unsigned,
               m_i_rd_addr, m_i_reg_write, m_i_ack, m_i_rdata,
        output m_o_ready, m_o_req, m_o_we, m_o_addr, m_o_wdata, m_o_wstrb,
               m_o_valid, m_o_wb_data, m_o_rd_addr, m_o_reg_write, m_o_pc,
               m_o_misalign, m_o_timeout
    );

    // Whatever surrounds the stage: ALU, data memory and writeback
    modport master (
        output m_i_valid, m_i_alu_value, m_i_data_rt, m_i_alu_pc,
               m_i_mem_read, m_i_mem_write, m_i_size, m_i_unsigned,
               m_i_rd_addr, m_i_reg_write, m_i_ack, m_i_rdata,
        input  m_o_ready, m_o_req, m_o_we, m_o_addr, m_o_wdata, m_o_wstrb,
               m_o_valid, m_o_wb_data, m_o_rd_addr, m_o_reg_write, m_o_pc,
               m_o_misalign, m_o_timeout
    );
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: passes ALU results through to writeback or
// performs a byte/half/word load or store on a single-outstanding req/ack bus,
// with lane alignment, load extension, misalignment and bus timeout flags.
module mem_access #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int TIMEOUT  = 16
) (
    input logic         i_clk,
    input logic         i_rst,
    mem_access_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_next;
    logic                accept, pass_thru, go_misalign, start_access;
    logic                ack_hit, timeout_hit;
    logic                is_mem, is_store, misaligned;
    logic [CW-1:0]       tcount;
    logic [1:0]          off_q, size_q;
    logic                uns_q, load_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [DWIDTH-1:0]   store_data, shifted, load_data;
    logic [3:0]          store_strb;

    assign is_mem     = bus.m_i_mem_read | bus.m_i_mem_write;
    assign is_store   = bus.m_i_mem_write;
    assign misaligned = ((bus.m_i_size == 2'b01) && bus.m_i_alu_value[0]) ||
                        (bus.m_i_size[1] && (bus.m_i_alu_value[1:0] != 2'b00));
    assign bus.m_o_ready = (state == IDLE);
    assign bus.m_o_pc    = pc_q;

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the one-cycle event strobes that steer the datapath
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        pass_thru    = 1'b0;
        go_misalign  = 1'b0;
        start_access = 1'b0;
        ack_hit      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m_i_valid) begin
                    accept = 1'b1;
                    if (!is_mem) begin
                        pass_thru = 1'b1;
                    end else if (misaligned) begin
                        go_misalign = 1'b1;
                        state_next  = RESP;
                    end else begin
                        start_access = 1'b1;
                        state_next   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.m_i_ack) begin
                    ack_hit    = 1'b1;
                    state_next = RESP;
                end else if (tcount == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Store lane replication and strobes from size and the low address bits
    always_comb begin
        store_data = bus.m_i_data_rt;
        store_strb = 4'b1111;
        case (bus.m_i_size)
            2'b00: begin
                store_data = {4{bus.m_i_data_rt[7:0]}};
                store_strb = 4'b0001 << bus.m_i_alu_value[1:0];
            end
            2'b01: begin
                store_data = {2{bus.m_i_data_rt[15:0]}};
                store_strb = 4'b0011 << {bus.m_i_alu_value[1], 1'b0};
            end
            default: begin
                store_data = bus.m_i_data_rt;
                store_strb = 4'b1111;
            end
        endcase
    end

    // Load lane selection and sign/zero extension of the returned word
    always_comb begin
        shifted   = bus.m_i_rdata >> {off_q, 3'b000};
        load_data = bus.m_i_rdata;
        case (size_q)
            2'b00:   load_data = uns_q ? {{(DWIDTH-8){1'b0}}, shifted[7:0]}
                                       : {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {{(DWIDTH-16){1'b0}}, shifted[15:0]}
                                       : {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            default: load_data = bus.m_i_rdata;
        endcase
    end

    // Bus request, timeout counter and writeback payload registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.m_o_req       <= 1'b0;
            bus.m_o_we        <= 1'b0;
            bus.m_o_addr      <= '0;
            bus.m_o_wdata     <= '0;
            bus.m_o_wstrb     <= '0;
            bus.m_o_valid     <= 1'b0;
            bus.m_o_wb_data   <= '0;
            bus.m_o_rd_addr   <= '0;
            bus.m_o_reg_write <= 1'b0;
            bus.m_o_misalign  <= 1'b0;
            bus.m_o_timeout   <= 1'b0;
            pc_q              <= '0;
            tcount            <= '0;
            off_q             <= '0;
            size_q            <= '0;
            uns_q             <= 1'b0;
            load_q            <= 1'b0;
        end else begin
            bus.m_o_valid <= pass_thru | go_misalign | ack_hit | timeout_hit;
            if (accept) begin
                bus.m_o_rd_addr  <= bus.m_i_rd_addr;
                bus.m_o_wb_data  <= bus.m_i_alu_value;
                bus.m_o_misalign <= 1'b0;
                bus.m_o_timeout  <= 1'b0;
                pc_q             <= bus.m_i_alu_pc;
            end
            if (pass_thru) begin
                bus.m_o_reg_write <= bus.m_i_reg_write;
            end
            if (go_misalign) begin
                bus.m_o_misalign  <= 1'b1;
                bus.m_o_reg_write <= 1'b0;
            end
            if (start_access) begin
                bus.m_o_req       <= 1'b1;
                bus.m_o_we        <= is_store;
                bus.m_o_addr      <= {bus.m_i_alu_value[DWIDTH-1:2], 2'b00};
                bus.m_o_wdata     <= store_data;
                bus.m_o_wstrb     <= store_strb;
                bus.m_o_reg_write <= is_store ? 1'b0 : bus.m_i_reg_write;
                off_q             <= bus.m_i_alu_value[1:0];
                size_q            <= bus.m_i_size;
                uns_q             <= bus.m_i_unsigned;
                load_q            <= ~is_store;
                tcount            <= '0;
            end
            if (ack_hit) begin
                bus.m_o_req <= 1'b0;
                bus.m_o_we  <= 1'b0;
                if (load_q) bus.m_o_wb_data <= load_data;
            end else if (timeout_hit) begin
                bus.m_o_req       <= 1'b0;
                bus.m_o_we        <= 1'b0;
                bus.m_o_timeout   <= 1'b1;
                bus.m_o_reg_write <= 1'b0;
            end else if (state == ACCESS) begin
                tcount <= tcount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a driver pushes expected writeback
// results into a scoreboard, a memory responder acks after a chosen number
// of wait cycles, and a monitor pops and compares every retire pulse.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passCount = 0;
    int   totalCount = 0;

    typedef struct {
        logic [31:0] wb;
        bit          chkWb;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] pc;
        logic        mis;
        logic        tmo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t popped;

    int          respWait = -1;
    logic [31:0] respRdata = '0;
    logic [31:0] expAddr = '0;
    logic        expWe = 1'b0;
    logic [3:0]  expStrb = '0;
    logic [31:0] expWdata = '0;
    bit          chkStore = 1'b0;
    int          reqCycles = 0;
    bit          ackPrev = 1'b0;

    mem_access_if #(.DWIDTH(32), .PC_WIDTH(32)) bus ();

    mem_access #(.DWIDTH(32), .PC_WIDTH(32), .TIMEOUT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, act, exp);
        else
            passCount++;
    endtask

    task automatic applyStimulus(
        input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] pc,
        input logic [4:0] rd, input logic rdm, input logic wrm,
        input logic [1:0] sz, input logic uns, input logic rw,
        input int waits, input logic [31:0] rdata,
        input logic [31:0] eWb, input bit cWb, input logic eRw,
        input logic eMis, input logic eTmo, input int eLat,
        input logic [3:0] eStrb, input logic [31:0] eWdata,
        input bit push, output int acc);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!bus.m_o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.m_o_ready) checkOutput("ready_wait", 32'(bus.m_o_ready), 32'd1);
        bus.m_i_valid     = 1'b1;
        bus.m_i_alu_value = alu;
        bus.m_i_data_rt   = rt;
        bus.m_i_alu_pc    = pc;
        bus.m_i_rd_addr   = rd;
        bus.m_i_mem_read  = rdm;
        bus.m_i_mem_write = wrm;
        bus.m_i_size      = sz;
        bus.m_i_unsigned  = uns;
        bus.m_i_reg_write = rw;
        respWait  = waits;
        respRdata = rdata;
        expAddr   = alu & 32'hFFFF_FFFC;
        expWe     = wrm;
        expStrb   = eStrb;
        expWdata  = eWdata;
        chkStore  = wrm;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e.wb = eWb; e.chkWb = cWb; e.rd = rd; e.rw = eRw; e.pc = pc;
            e.mis = eMis; e.tmo = eTmo; e.acc = acc; e.lat = eLat;
            sb.push_back(e);
        end
        bus.m_i_valid     = 1'b0;
        bus.m_i_mem_read  = 1'b0;
        bus.m_i_mem_write = 1'b0;
    endtask

    // Memory responder: checks the held request and acks after respWait cycles
    initial begin
        bus.m_i_ack   = 1'b0;
        bus.m_i_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_i_ack = 1'b0;
            if (rst) begin
                reqCycles = 0;
                ackPrev   = 1'b0;
            end else begin
                if (ackPrev) checkOutput("req_after_ack", 32'(bus.m_o_req), 32'd0);
                ackPrev = 1'b0;
                if (bus.m_o_req) begin
                    checkOutput("ready_busy", 32'(bus.m_o_ready), 32'd0);
                    checkOutput("bus_addr", bus.m_o_addr, expAddr);
                    checkOutput("bus_we", 32'(bus.m_o_we), 32'(expWe));
                    if (chkStore) begin
                        checkOutput("bus_wstrb", 32'(bus.m_o_wstrb), 32'(expStrb));
                        checkOutput("bus_wdata", bus.m_o_wdata, expWdata);
                    end
                    if (reqCycles == respWait) begin
                        bus.m_i_ack   = 1'b1;
                        bus.m_i_rdata = respRdata;
                        ackPrev       = 1'b1;
                    end
                    reqCycles++;
                end else begin
                    reqCycles = 0;
                end
            end
        end
    end

    // Monitor: every retire pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bus.m_o_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", 32'(bus.m_o_valid), 32'd0);
            end else begin
                popped = sb.pop_front();
                if (popped.chkWb) checkOutput("wb_data", bus.m_o_wb_data, popped.wb);
                checkOutput("rd_addr", 32'(bus.m_o_rd_addr), 32'(popped.rd));
                checkOutput("reg_write", 32'(bus.m_o_reg_write), 32'(popped.rw));
                checkOutput("pc", bus.m_o_pc, popped.pc);
                checkOutput("misalign", 32'(bus.m_o_misalign), 32'(popped.mis));
                checkOutput("timeout", 32'(bus.m_o_timeout), 32'(popped.tmo));
                checkOutput("latency", 32'(cyc - popped.acc + 1), 32'(popped.lat));
            end
        end
    end

    initial begin
        int a0, a1, n, guard;
        bus.m_i_valid = 1'b0; bus.m_i_alu_value = '0; bus.m_i_data_rt = '0;
        bus.m_i_alu_pc = '0; bus.m_i_rd_addr = '0; bus.m_i_mem_read = 1'b0;
        bus.m_i_mem_write = 1'b0; bus.m_i_size = '0; bus.m_i_unsigned = 1'b0;
        bus.m_i_reg_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(bus.m_o_ready), 32'd1);
        checkOutput("rst_req", 32'(bus.m_o_req), 32'd0);
        checkOutput("rst_we", 32'(bus.m_o_we), 32'd0);
        checkOutput("rst_valid", 32'(bus.m_o_valid), 32'd0);
        checkOutput("rst_wb_data", bus.m_o_wb_data, 32'd0);
        checkOutput("rst_addr", bus.m_o_addr, 32'd0);
        checkOutput("rst_wstrb", 32'(bus.m_o_wstrb), 32'd0);
        checkOutput("rst_flags", 32'({bus.m_o_reg_write, bus.m_o_misalign, bus.m_o_timeout}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back pass-through
        applyStimulus(32'd9, 32'd0, 32'h40, 5'd3, 0, 0, 2'b10, 0, 1, -1, 32'd0,
                      32'd9, 1, 1, 0, 0, 1, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h55, 32'd0, 32'h44, 5'd4, 0, 0, 2'b10, 0, 0, -1, 32'd0,
                      32'h55, 1, 0, 0, 0, 1, 4'h0, 32'd0, 1, a1);
        checkOutput("back_to_back", 32'(a1 - a0), 32'd1);

        // Loads: signed byte, unsigned half with waits, signed half, word
        applyStimulus(32'h102, 32'd0, 32'h48, 5'd5, 1, 0, 2'b00, 0, 1, 0, 32'h0080_0000,
                      32'hFFFF_FF80, 1, 1, 0, 0, 2, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h106, 32'd0, 32'h4C, 5'd6, 1, 0, 2'b01, 1, 1, 3, 32'hBEEF_0000,
                      32'h0000_BEEF, 1, 1, 0, 0, 5, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h102, 32'd0, 32'h50, 5'd7, 1, 0, 2'b01, 0, 1, 1, 32'h8001_0000,
                      32'hFFFF_8001, 1, 1, 0, 0, 3, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h300, 32'd0, 32'h54, 5'd8, 1, 0, 2'b11, 0, 1, 0, 32'h89AB_CDEF,
                      32'h89AB_CDEF, 1, 1, 0, 0, 2, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h301, 32'd0, 32'h56, 5'd8, 1, 0, 2'b00, 1, 1, 0, 32'h89AB_CDEF,
                      32'h0000_00CD, 1, 1, 0, 0, 2, 4'h0, 32'd0, 1, a0);

        // Stores: byte at lane 3, half at upper lanes, word; mem_read ignored
        applyStimulus(32'h203, 32'h1234_56AB, 32'h58, 5'd9, 0, 1, 2'b00, 0, 1, 0, 32'd0,
                      32'd0, 0, 0, 0, 0, 2, 4'b1000, 32'hABAB_ABAB, 1, a0);
        applyStimulus(32'h206, 32'h0000_CAFE, 32'h5C, 5'd10, 1, 1, 2'b01, 0, 1, 2, 32'd0,
                      32'd0, 0, 0, 0, 0, 4, 4'b1100, 32'hCAFE_CAFE, 1, a0);
        applyStimulus(32'h208, 32'hDEAD_BEEF, 32'h60, 5'd11, 0, 1, 2'b10, 0, 1, 0, 32'd0,
                      32'd0, 0, 0, 0, 0, 2, 4'b1111, 32'hDEAD_BEEF, 1, a0);

        // Misaligned word load and half store: no request issued
        applyStimulus(32'h102, 32'd0, 32'h64, 5'd12, 1, 0, 2'b10, 0, 1, 0, 32'd0,
                      32'd0, 0, 0, 1, 0, 1, 4'h0, 32'd0, 1, a0);
        checkOutput("misalign_noreq", 32'(bus.m_o_req), 32'd0);
        applyStimulus(32'h101, 32'h1111, 32'h68, 5'd13, 0, 1, 2'b01, 0, 1, 0, 32'd0,
                      32'd0, 0, 0, 1, 0, 1, 4'h0, 32'd0, 1, a0);
        checkOutput("misalign_st_noreq", 32'(bus.m_o_req), 32'd0);

        // Ack on the very edge the timeout would fire: ack wins
        applyStimulus(32'h400, 32'd0, 32'h6C, 5'd14, 1, 0, 2'b10, 0, 1, 3, 32'h1357_9BDF,
                      32'h1357_9BDF, 1, 1, 0, 0, 5, 4'h0, 32'd0, 1, a0);

        // No ack at all: request held for exactly 4 cycles, then timeout
        applyStimulus(32'h500, 32'd0, 32'h70, 5'd15, 1, 0, 2'b10, 0, 1, -1, 32'd0,
                      32'd0, 0, 0, 0, 1, 5, 4'h0, 32'd0, 1, a0);
        n = 0;
        guard = 0;
        @(negedge clk);
        while (bus.m_o_req && guard < 20) begin
            n++;
            guard++;
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", 32'(n), 32'd4);

        // Reset in the middle of an access discards the instruction
        applyStimulus(32'h600, 32'd0, 32'h74, 5'd16, 1, 0, 2'b10, 0, 1, -1, 32'd0,
                      32'd0, 0, 0, 0, 0, 0, 4'h0, 32'd0, 0, a0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_req", 32'(bus.m_o_req), 32'd0);
        checkOutput("midrst_valid", 32'(bus.m_o_valid), 32'd0);
        checkOutput("midrst_ready", 32'(bus.m_o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Recovery after reset
        applyStimulus(32'h2A, 32'd0, 32'h78, 5'd17, 0, 0, 2'b10, 0, 1, -1, 32'd0,
                      32'h2A, 1, 1, 0, 0, 1, 4'h0, 32'd0, 1, a0);
        applyStimulus(32'h700, 32'd0, 32'h7C, 5'd18, 1, 0, 2'b00, 1, 1, 0, 32'h0000_00F0,
                      32'h0000_00F0, 1, 1, 0, 0, 2, 4'h0, 32'd0, 1, a0);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
